// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared types and constants for the register-file write arbiter
package reg_pkg;

    // Arbiter operating state: zero sweep after reset/clear, then normal arbitration.
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } arb_state_t;

    localparam int REG_NREGS = 32;
    localparam int REG_AW    = 5;
    localparam int REG_DW    = 32;
    localparam int REG_ZERO  = 31;
    localparam int REG_MAX_WAIT = 8;

    // Width needed to hold a saturating count up to max_wait inclusive.
    function automatic int starve_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/reg_clear_seq.sv
// rtl/reg_clear_seq.sv - zero-sweep address pointer with hardwired-zero skip
import reg_pkg::*;

module reg_clear_seq #(
    parameter int NREGS    = REG_NREGS,
    parameter int AW       = REG_AW,
    parameter int ZERO_REG = REG_ZERO
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart_i,
    input  logic          adv_i,
    output logic [AW-1:0] ptr_o,
    output logic          last_o
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 2);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;
    logic [AW-1:0] ptr_inc;

    // Next pointer: restart wins, otherwise step past the hardwired-zero index.
    always_comb begin
        ptr_d   = ptr_q;
        ptr_inc = ptr_q + AW'(1);
        if (ptr_inc == ZERO_IDX) begin
            ptr_inc = ptr_inc + AW'(1);
        end
        if (restart_i) begin
            ptr_d = '0;
        end else if (adv_i) begin
            ptr_d = ptr_inc;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o  = ptr_q;
    // High while the pointer holds the final writable index of the sweep.
    assign last_o = (ptr_q == LAST_IDX);

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - register-file write port owner: zero sweep plus wb/debug arbitration (optional REG_WR_STATS_EN)
import reg_pkg::*;

module reg_write_arbiter #(
    parameter int NREGS    = REG_NREGS,
    parameter int AW       = REG_AW,
    parameter int DW       = REG_DW,
    parameter int ZERO_REG = REG_ZERO,
    parameter int MAX_WAIT = REG_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          dbg_valid,
    output logic          dbg_ready,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          init_done
`ifdef REG_WR_STATS_EN
    ,
    output logic [31:0]   stat_wb_cnt,
    output logic [31:0]   stat_dbg_cnt,
    output logic [31:0]   stat_drop_cnt
`endif
);

    localparam int              SW       = starve_width(MAX_WAIT);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [AW-1:0]   ZERO_IDX = AW'(ZERO_REG);

    arb_state_t    state_q;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          rf_we_q;
    logic [AW-1:0] rf_wa_q;
    logic [DW-1:0] rf_wd_q;
    logic          init_done_q;

    logic          in_run;
    logic          force_dbg;
    logic          wb_acc;
    logic          dbg_acc;
    logic          clr_now;
    logic [AW-1:0] seq_ptr;
    logic          seq_last;

    reg_clear_seq #(
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .restart_i (clr_now),
        .adv_i     (state_q == S_CLEAR),
        .ptr_o     (seq_ptr),
        .last_o    (seq_last)
    );

    // Ready/accept decode: a pending clear blocks both sides, force hands the port to debug.
    always_comb begin
        in_run    = (state_q == S_RUN);
        clr_now   = in_run && clr_req;
        force_dbg = in_run && (starve_q == STARVE_MAX) && dbg_valid;
        wb_ready  = in_run && !clr_req && !force_dbg;
        dbg_ready = in_run && !clr_req && (force_dbg || !wb_valid);
        wb_acc    = wb_valid && wb_ready;
        dbg_acc   = dbg_valid && dbg_ready;
    end

    // Starvation count: grows while debug waits, saturates, clears on accept or idle.
    always_comb begin
        starve_d = starve_q;
        if (!in_run || clr_req || dbg_acc || !dbg_valid) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Main FSM with registered write-port and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            starve_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                S_CLEAR: begin
                    rf_we_q <= 1'b1;
                    rf_wa_q <= seq_ptr;
                    rf_wd_q <= '0;
                    if (seq_last) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (clr_req) begin
                        state_q     <= S_CLEAR;
                        init_done_q <= 1'b0;
                        rf_we_q     <= 1'b0;
                    end else if (wb_acc) begin
                        rf_we_q <= (wb_addr != ZERO_IDX);
                        rf_wa_q <= wb_addr;
                        rf_wd_q <= wb_data;
                    end else if (dbg_acc) begin
                        rf_we_q <= (dbg_addr != ZERO_IDX);
                        rf_wa_q <= dbg_addr;
                        rf_wd_q <= dbg_data;
                    end else begin
                        rf_we_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_CLEAR;
                    rf_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_wa     = rf_wa_q;
    assign rf_wd     = rf_wd_q;
    assign init_done = init_done_q;

`ifdef REG_WR_STATS_EN
    logic [31:0] stat_wb_q;
    logic [31:0] stat_dbg_q;
    logic [31:0] stat_drop_q;
    logic        drop_acc;

    assign drop_acc = (wb_acc && (wb_addr == ZERO_IDX)) || (dbg_acc && (dbg_addr == ZERO_IDX));

    // Accept counters; wrap naturally and restart when a soft clear is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_wb_q   <= '0;
            stat_dbg_q  <= '0;
            stat_drop_q <= '0;
        end else if (clr_now) begin
            stat_wb_q   <= '0;
            stat_dbg_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            if (wb_acc) begin
                stat_wb_q <= stat_wb_q + 32'd1;
            end
            if (dbg_acc) begin
                stat_dbg_q <= stat_dbg_q + 32'd1;
            end
            if (drop_acc) begin
                stat_drop_q <= stat_drop_q + 32'd1;
            end
        end
    end

    assign stat_wb_cnt   = stat_wb_q;
    assign stat_dbg_cnt  = stat_dbg_q;
    assign stat_drop_cnt = stat_drop_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic        clk;
    logic        rst;
    logic        clr_req;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        init_done;
`ifdef REG_WR_STATS_EN
    logic [31:0] stat_wb_cnt;
    logic [31:0] stat_dbg_cnt;
    logic [31:0] stat_drop_cnt;
`endif

    int total;
    int bad;

    logic [31:0] rf_model [32];

    reg_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .dbg_valid (dbg_valid),
        .dbg_ready (dbg_ready),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .init_done (init_done)
`ifdef REG_WR_STATS_EN
        ,
        .stat_wb_cnt   (stat_wb_cnt),
        .stat_dbg_cnt  (stat_dbg_cnt),
        .stat_drop_cnt (stat_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) rf_model[rf_wa] <= rf_wd;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_req = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        dbg_valid = 1'b1; dbg_addr = 5'd4; dbg_data = 32'h22;
        step(); step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0b want=0", rf_we); end
        total++; if (rf_wa !== 5'd0) begin bad++; $display("FAIL reset_rf_wa got=%0d want=0", rf_wa); end
        total++; if (rf_wd !== 32'd0) begin bad++; $display("FAIL reset_rf_wd got=%h want=0", rf_wd); end
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%0b want=0", init_done); end
        total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL reset_wb_ready got=%0b want=0", wb_ready); end
        total++; if (dbg_ready !== 1'b0) begin bad++; $display("FAIL reset_dbg_ready got=%0b want=0", dbg_ready); end
        wb_valid = 1'b0; dbg_valid = 1'b0;
    endtask

    task automatic test_sweep();
        rst = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            step();
            total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL sweep_we k=%0d got=%0b want=1", k, rf_we); end
            total++; if (rf_wa !== 5'(k - 1)) begin bad++; $display("FAIL sweep_wa k=%0d got=%0d want=%0d", k, rf_wa, k - 1); end
            total++; if (rf_wd !== 32'd0) begin bad++; $display("FAIL sweep_wd k=%0d got=%h want=0", k, rf_wd); end
            total++; if (init_done !== (k == 31)) begin bad++; $display("FAIL sweep_done k=%0d got=%0b want=%0b", k, init_done, (k == 31)); end
            if (k < 31) begin
                total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL sweep_wb_ready k=%0d got=%0b want=0", k, wb_ready); end
            end
        end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL post_sweep_we got=%0b want=0", rf_we); end
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL post_sweep_done got=%0b want=1", init_done); end
        total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL run_wb_ready got=%0b want=1", wb_ready); end
        total++; if (dbg_ready !== 1'b1) begin bad++; $display("FAIL run_dbg_ready got=%0b want=1", dbg_ready); end
        for (int r = 0; r < 31; r++) begin
            total++; if (rf_model[r] !== 32'd0) begin bad++; $display("FAIL sweep_rf r=%0d got=%h want=0", r, rf_model[r]); end
        end
    endtask

    task automatic test_wb_write();
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL wb_ready got=%0b want=1", wb_ready); end
        step();
        wb_valid = 1'b0;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL wb_we got=%0b want=1", rf_we); end
        total++; if (rf_wa !== 5'd5) begin bad++; $display("FAIL wb_wa got=%0d want=5", rf_wa); end
        total++; if (rf_wd !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_wd got=%h want=deadbeef", rf_wd); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL wb_we_drop got=%0b want=0", rf_we); end
        total++; if (rf_model[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_rf got=%h want=deadbeef", rf_model[5]); end
    endtask

    task automatic test_starvation();
        dbg_valid = 1'b1; dbg_addr = 5'd2; dbg_data = 32'hD0D0;
        wb_valid = 1'b1; wb_addr = 5'd1;
        for (int c = 1; c <= 8; c++) begin
            wb_data = 32'h1000 + 32'(c);
            #1;
            total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL starve_wb_ready c=%0d got=%0b want=1", c, wb_ready); end
            total++; if (dbg_ready !== 1'b0) begin bad++; $display("FAIL starve_dbg_ready c=%0d got=%0b want=0", c, dbg_ready); end
            step();
            total++; if (rf_wd !== 32'h1000 + 32'(c)) begin bad++; $display("FAIL starve_wb_wd c=%0d got=%h want=%h", c, rf_wd, 32'h1000 + 32'(c)); end
        end
        wb_data = 32'h2000;
        #1;
        total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL force_wb_ready got=%0b want=0", wb_ready); end
        total++; if (dbg_ready !== 1'b1) begin bad++; $display("FAIL force_dbg_ready got=%0b want=1", dbg_ready); end
        step();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL force_we got=%0b want=1", rf_we); end
        total++; if (rf_wa !== 5'd2) begin bad++; $display("FAIL force_wa got=%0d want=2", rf_wa); end
        total++; if (rf_wd !== 32'hD0D0) begin bad++; $display("FAIL force_wd got=%h want=d0d0", rf_wd); end
        #1;
        total++; if (dbg_ready !== 1'b0) begin bad++; $display("FAIL starve_cleared_dbg got=%0b want=0", dbg_ready); end
        total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL starve_cleared_wb got=%0b want=1", wb_ready); end
        wb_valid = 1'b0; dbg_valid = 1'b0;
        step();
    endtask

    task automatic test_zero_write();
        dbg_valid = 1'b1; dbg_addr = 5'd31; dbg_data = 32'h1234;
        #1;
        total++; if (dbg_ready !== 1'b1) begin bad++; $display("FAIL zero_dbg_ready got=%0b want=1", dbg_ready); end
        step();
        dbg_valid = 1'b0;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL zero_we got=%0b want=0", rf_we); end
`ifdef REG_WR_STATS_EN
        total++; if (stat_drop_cnt !== 32'd1) begin bad++; $display("FAIL stat_drop got=%0d want=1", stat_drop_cnt); end
        total++; if (stat_wb_cnt !== 32'd9) begin bad++; $display("FAIL stat_wb got=%0d want=9", stat_wb_cnt); end
        total++; if (stat_dbg_cnt !== 32'd2) begin bad++; $display("FAIL stat_dbg got=%0d want=2", stat_dbg_cnt); end
`endif
    endtask

    task automatic test_clear();
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE;
        clr_req = 1'b1;
        #1;
        total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL clr_wb_ready got=%0b want=0", wb_ready); end
        total++; if (dbg_ready !== 1'b0) begin bad++; $display("FAIL clr_dbg_ready got=%0b want=0", dbg_ready); end
        step();
        clr_req = 1'b0;
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL clr_init_done got=%0b want=0", init_done); end
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL clr_we got=%0b want=0", rf_we); end
`ifdef REG_WR_STATS_EN
        total++; if (stat_drop_cnt !== 32'd0) begin bad++; $display("FAIL clr_stat_drop got=%0d want=0", stat_drop_cnt); end
`endif
        for (int k = 1; k <= 31; k++) begin
            step();
            total++; if (rf_we !== 1'b1 || rf_wa !== 5'(k - 1) || rf_wd !== 32'd0) begin
                bad++; $display("FAIL clr_sweep k=%0d got we=%0b wa=%0d wd=%h want we=1 wa=%0d wd=0", k, rf_we, rf_wa, rf_wd, k - 1);
            end
        end
        total++; if (rf_model[5] !== 32'd0) begin bad++; $display("FAIL clr_rf5 got=%h want=0", rf_model[5]); end
        total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL clr_resume_ready got=%0b want=1", wb_ready); end
        step();
        wb_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'hCAFE) begin
            bad++; $display("FAIL clr_held_wb got we=%0b wa=%0d wd=%h want we=1 wa=7 wd=cafe", rf_we, rf_wa, rf_wd);
        end
`ifdef REG_WR_STATS_EN
        total++; if (stat_wb_cnt !== 32'd1) begin bad++; $display("FAIL clr_stat_wb got=%0d want=1", stat_wb_cnt); end
`endif
    endtask

    task automatic test_reset_mid_sweep();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        total++; if (rf_wa !== 5'd11) begin bad++; $display("FAIL mid_pre_wa got=%0d want=11", rf_wa); end
        rst = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we got=%0b want=0", rf_we); end
        total++; if (rf_wa !== 5'd0) begin bad++; $display("FAIL mid_rst_wa got=%0d want=0", rf_wa); end
        step();
        rst = 1'b0;
        step();
        total++; if (rf_we !== 1'b1 || rf_wa !== 5'd0) begin bad++; $display("FAIL mid_restart0 got we=%0b wa=%0d want we=1 wa=0", rf_we, rf_wa); end
        step();
        total++; if (rf_wa !== 5'd1) begin bad++; $display("FAIL mid_restart1 got=%0d want=1", rf_wa); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_sweep();
        test_wb_write();
        test_starvation();
        test_zero_write();
        test_clear();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
